// File: rtl/alu_seq_core.sv
// Sequential ALU: handshaked operand capture, single-cycle logic/arith ops,
// iterative shift-add multiply and restoring divide, held result with flags.
module alu_seq_core #(
    parameter int WIDTH = 8,
    parameter int CMD_W = 4,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [CMD_W-1:0]     command_in,
    input  logic                 oe,
    output logic [2*WIDTH-1:0]   alu_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 zero_flag,
    output logic                 err_flag
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CMD_W-1:0] OP_ADD = CMD_W'(0);
    localparam logic [CMD_W-1:0] OP_SUB = CMD_W'(1);
    localparam logic [CMD_W-1:0] OP_MUL = CMD_W'(2);
    localparam logic [CMD_W-1:0] OP_DIV = CMD_W'(3);
    localparam logic [CMD_W-1:0] OP_MOD = CMD_W'(4);
    localparam logic [CMD_W-1:0] OP_AND = CMD_W'(5);
    localparam logic [CMD_W-1:0] OP_OR  = CMD_W'(6);
    localparam logic [CMD_W-1:0] OP_XOR = CMD_W'(7);
    localparam logic [CMD_W-1:0] OP_NOT = CMD_W'(8);
    localparam logic [CMD_W-1:0] OP_SHL = CMD_W'(9);
    localparam logic [CMD_W-1:0] OP_SHR = CMD_W'(10);
    localparam logic [CMD_W-1:0] OP_CMP = CMD_W'(11);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic [CMD_W-1:0] cmd_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [RW-1:0]    prod_reg, mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg;
    logic [RW-1:0]    result_reg;
    logic             zero_flag_reg, err_flag_reg;

    logic accept;
    logic iter_op;
    logic iter_last;
    logic is_mul;

    assign accept    = in_valid && (state_reg == S_IDLE);
    assign is_mul    = (cmd_reg == OP_MUL);
    // Divide by zero bypasses the iterative divider and completes in one cycle.
    assign iter_op   = is_mul ||
                       (((cmd_reg == OP_DIV) || (cmd_reg == OP_MOD)) && (b_reg != '0));
    assign iter_last = (cnt_reg == CNT_W'(WIDTH));

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = S_EXEC;
            S_EXEC: if (!iter_op || iter_last) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0] add_sum, sub_diff;
    assign add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    assign sub_diff = {1'b0, a_reg} - {1'b0, b_reg};

    // Logarithmic shifters: stage gi shifts by 2**gi when b[gi] is set.
    logic [RW-1:0]    shl_stage [0:SH_W];
    logic [WIDTH-1:0] shr_stage [0:SH_W];
    assign shl_stage[0] = {{WIDTH{1'b0}}, a_reg};
    assign shr_stage[0] = a_reg;

    generate
        for (genvar gi = 0; gi < SH_W; gi++) begin : g_shift
            assign shl_stage[gi+1] = b_reg[gi] ? (shl_stage[gi] << (2**gi)) : shl_stage[gi];
            assign shr_stage[gi+1] = b_reg[gi] ? (shr_stage[gi] >> (2**gi)) : shr_stage[gi];
        end
    endgenerate

    logic [RW-1:0] single_res;
    logic          single_err;

    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (cmd_reg)
            OP_ADD: single_res[WIDTH:0] = add_sum;
            OP_SUB: single_res[WIDTH:0] = sub_diff;
            OP_MUL: single_res = '0;
            OP_DIV: begin
                single_res[WIDTH-1:0] = '1;
                single_err = 1'b1;
            end
            OP_MOD: begin
                single_res[WIDTH-1:0] = a_reg;
                single_err = 1'b1;
            end
            OP_AND: single_res[WIDTH-1:0] = a_reg & b_reg;
            OP_OR:  single_res[WIDTH-1:0] = a_reg | b_reg;
            OP_XOR: single_res[WIDTH-1:0] = a_reg ^ b_reg;
            OP_NOT: single_res[WIDTH-1:0] = ~a_reg;
            OP_SHL: single_res = shl_stage[SH_W];
            OP_SHR: single_res[WIDTH-1:0] = shr_stage[SH_W];
            OP_CMP: begin
                single_res[0] = (a_reg < b_reg);
                single_res[1] = (a_reg == b_reg);
                single_res[2] = (a_reg > b_reg);
            end
            default: single_err = 1'b1;
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic [RW-1:0]    prod_next;
    logic [WIDTH:0]   rem_shift, rem_trial;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [RW-1:0]    iter_res;

    assign prod_next = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;

    // The remainder stays below the divisor, so the trial difference's top bit
    // is a clean borrow indicator.
    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, b_reg};
    assign div_ge    = ~rem_trial[WIDTH];
    assign rem_next  = div_ge ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next  = {quo_reg[WIDTH-2:0], div_ge};

    always_comb begin
        iter_res = '0;
        if (is_mul) begin
            iter_res = prod_reg;
        end else if (cmd_reg == OP_DIV) begin
            iter_res[WIDTH-1:0] = quo_reg;
        end else begin
            iter_res[WIDTH-1:0] = rem_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            cmd_reg       <= '0;
            cnt_reg       <= '0;
            prod_reg      <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            result_reg    <= '0;
            zero_flag_reg <= 1'b0;
            err_flag_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        a_reg        <= a_in;
                        b_reg        <= b_in;
                        cmd_reg      <= command_in;
                        err_flag_reg <= 1'b0;
                        cnt_reg      <= '0;
                        prod_reg     <= '0;
                        mcand_reg    <= {{WIDTH{1'b0}}, a_in};
                        mplier_reg   <= b_in;
                        rem_reg      <= '0;
                        quo_reg      <= a_in;
                    end
                end
                S_EXEC: begin
                    if (!iter_op) begin
                        result_reg    <= single_res;
                        zero_flag_reg <= (single_res == '0);
                        err_flag_reg  <= single_err;
                    end else if (iter_last) begin
                        result_reg    <= iter_res;
                        zero_flag_reg <= (iter_res == '0);
                        err_flag_reg  <= 1'b0;
                    end else begin
                        // Multiplier and divider step together; the result mux picks one.
                        cnt_reg    <= cnt_reg + CNT_W'(1);
                        prod_reg   <= prod_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        rem_reg    <= rem_next;
                        quo_reg    <= quo_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign zero_flag = zero_flag_reg;
    assign err_flag  = err_flag_reg;
    assign alu_out   = oe ? result_reg : {RW{1'bz}};

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed and randomized checks of alu_seq_core (WIDTH=8) against an
// arithmetic reference model.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic [3:0]  command_in = '0;
    logic        oe = 1'b1;
    wire  [15:0] alu_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        zero_flag;
    logic        err_flag;

    int tests = 0;
    int fails = 0;

    alu_seq_core #(.WIDTH(8), .CMD_W(4), .SH_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .command_in (command_in),
        .oe         (oe),
        .alu_out    (alu_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .zero_flag  (zero_flag),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: {err, zero, result} from plain arithmetic.
    function automatic logic [17:0] model(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        logic        e;
        r = '0;
        e = 1'b0;
        case (cmd)
            4'd0:  r = 16'(a) + 16'(b);
            4'd1:  begin r[7:0] = a - b; r[8] = (a < b); end
            4'd2:  r = 16'(a) * 16'(b);
            4'd3:  if (b == 0) begin r = 16'h00FF; e = 1'b1; end else r[7:0] = a / b;
            4'd4:  if (b == 0) begin r[7:0] = a; e = 1'b1; end else r[7:0] = a % b;
            4'd5:  r[7:0] = a & b;
            4'd6:  r[7:0] = a | b;
            4'd7:  r[7:0] = a ^ b;
            4'd8:  r[7:0] = ~a;
            4'd9:  r = {8'h00, a} << b[2:0];
            4'd10: r[7:0] = a >> b[2:0];
            4'd11: begin r[0] = (a < b); r[1] = (a == b); r[2] = (a > b); end
            default: e = 1'b1;
        endcase
        return {e, (r == 16'h0000), r};
    endfunction

    function automatic int model_lat(input logic [3:0] cmd, input logic [7:0] b);
        if (cmd == 4'd2) return 9;
        if ((cmd == 4'd3 || cmd == 4'd4) && b != 0) return 9;
        return 1;
    endfunction

    task automatic issue(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a_in = a;
        b_in = b;
        command_in = cmd;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        command_in = 4'($urandom);
        check("err_cleared_on_accept", 32'(err_flag), 32'd0);
        check("in_ready_low_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_done(input int lat_exp, input string tag);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    endtask

    task automatic check_out(input logic [15:0] res, input logic z, input logic e, input string tag);
        check({tag, "_result"}, 32'(alu_out), 32'(res));
        check({tag, "_zero"}, 32'(zero_flag), 32'(z));
        check({tag, "_err"}, 32'(err_flag), 32'(e));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_dropped"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input logic [15:0] res, input logic z, input logic e,
                          input string tag);
        issue(cmd, a, b);
        wait_done(lat, tag);
        check_out(res, z, e, tag);
        $display("[TB] %s cmd=%0d a=%h b=%h -> out=%h z=%b e=%b", tag, cmd, a, b, alu_out, zero_flag, err_flag);
        release_out(tag);
    endtask

    initial begin
        logic [17:0] m;
        logic [3:0]  rc;
        logic [7:0]  ra, rb;
        logic        gated;
        int          hold;

        // Reset state
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_zero", 32'(zero_flag), 32'd0);
        check("reset_err", 32'(err_flag), 32'd0);
        check("reset_result", 32'(alu_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations
        run_op(4'd0, 8'd15,  8'd10, 1, 16'h0019, 1'b0, 1'b0, "add_15_10");
        run_op(4'd0, 8'd255, 8'd1,  1, 16'h0100, 1'b0, 1'b0, "add_carry");
        run_op(4'd1, 8'd10,  8'd15, 1, 16'h01FB, 1'b0, 1'b0, "sub_borrow");
        run_op(4'd11, 8'd10, 8'd15, 1, 16'h0001, 1'b0, 1'b0, "cmp_lt");
        run_op(4'd2, 8'd255, 8'd255, 9, 16'hFE01, 1'b0, 1'b0, "mul_ff_ff");
        run_op(4'd3, 8'd15,  8'd10, 9, 16'h0001, 1'b0, 1'b0, "div_15_10");
        run_op(4'd4, 8'd15,  8'd10, 9, 16'h0005, 1'b0, 1'b0, "mod_15_10");
        run_op(4'd3, 8'd15,  8'd0,  1, 16'h00FF, 1'b0, 1'b1, "div_by_zero");
        run_op(4'd4, 8'd15,  8'd0,  1, 16'h000F, 1'b0, 1'b1, "mod_by_zero");
        run_op(4'd9, 8'hFF,  8'd7,  1, 16'h7F80, 1'b0, 1'b0, "shl_max");
        run_op(4'd10, 8'h80, 8'd7,  1, 16'h0001, 1'b0, 1'b0, "shr_max");

        // Backpressure and output enable
        issue(4'd7, 8'hF0, 8'hFF);
        wait_done(1, "xor_hold");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", 32'(alu_out), 32'h000F);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        oe = 1'b0;
        #1;
        gated = (alu_out === 16'hzzzz) || (alu_out === 16'h0000);
        check("oe_low_bus_released", 32'(gated), 32'd1);
        check("oe_low_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        oe = 1'b1;
        #1;
        check("oe_high_result", 32'(alu_out), 32'h000F);
        $display("[TB] xor_hold a=f0 b=ff -> out=%h held 4 cycles", alu_out);
        release_out("xor_hold");

        // out_ready and in_valid together in DONE: only the handshake completes
        issue(4'd5, 8'h3C, 8'h0F);
        wait_done(1, "and_overlap");
        check_out(16'h000C, 1'b0, 1'b0, "and_overlap");
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        command_in = 4'd0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("overlap_not_accepted", 32'(in_ready), 32'd1);
        check("overlap_out_valid", 32'(out_valid), 32'd0);
        $display("[TB] overlap done+in_valid -> in_ready=%b", in_ready);

        // Reset in the middle of a multiply
        issue(4'd2, 8'd200, 8'd3);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_result", 32'(alu_out), 32'd0);
        $display("[TB] reset mid-mul -> in_ready=%b out_valid=%b", in_ready, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd0, 8'd1, 8'd1, 1, 16'h0002, 1'b0, 1'b0, "add_after_reset");
        run_op(4'd15, 8'd7, 8'd9, 1, 16'h0000, 1'b1, 1'b1, "illegal_15");

        // Randomized operations with random consumer stalls
        for (int n = 0; n < 60; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            m = model(rc, ra, rb);
            issue(rc, ra, rb);
            wait_done(model_lat(rc, rb), "rand");
            check_out(m[15:0], m[16], m[17], "rand");
            $display("[TB] rand cmd=%0d a=%h b=%h -> out=%h z=%b e=%b", rc, ra, rb, alu_out, zero_flag, err_flag);
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check("rand_hold_result", 32'(alu_out), 32'(m[15:0]));
            end
            release_out("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
